// File: rtl/mem_arbiter.sv
// Two-client (fetch / load-store) arbiter in front of the memory controller, with watchdog abort.
// Optional round-robin tie-break when MEM_ARB_RR_EN is defined; fixed data priority otherwise.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_address,
   output logic        i_ack,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [31:0] d_address,
   input  logic [31:0] d_write_data,
   input  logic [1:0]  d_size,
   output logic        d_ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy,
   output logic        mem_rw_req,
   output logic [31:0] mem_address,
   output logic        mem_rw,
   output logic [31:0] mem_write_data,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_read_data,
   input  logic        mem_data_valid
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

   localparam logic [16:0] LP_TIMEOUT = 17'(TIMEOUT);

   state_t      r_state;
   logic        r_owner_d;
   logic [15:0] r_cnt;
   logic        r_i_ack;
   logic        r_d_ack;
   logic        r_err;
   logic        r_busy;
   logic [31:0] r_rdata;
   logic        r_mem_rw_req;
   logic [31:0] r_mem_address;
   logic        r_mem_rw;
   logic [31:0] r_mem_write_data;
   logic [1:0]  r_mem_size;

   logic        w_any_req;
   logic        w_grant_d;
   logic [16:0] w_cnt_inc;
   logic        w_timeout;

   assign w_any_req = i_req | d_req;
   assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
   assign w_timeout = (LP_TIMEOUT != 17'd0) && (w_cnt_inc == LP_TIMEOUT);

`ifdef MEM_ARB_RR_EN
   // r_last_d = 1 when the data client was granted most recently
   logic r_last_d;

   assign w_grant_d = d_req & (~i_req | ~r_last_d);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_d <= 1'b0;
      end else if (r_state == StIdle && w_any_req) begin
         r_last_d <= w_grant_d;
      end
   end
`else
   assign w_grant_d = d_req;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= StIdle;
         r_owner_d        <= 1'b0;
         r_cnt            <= '0;
         r_i_ack          <= 1'b0;
         r_d_ack          <= 1'b0;
         r_err            <= 1'b0;
         r_busy           <= 1'b0;
         r_rdata          <= '0;
         r_mem_rw_req     <= 1'b0;
         r_mem_address    <= '0;
         r_mem_rw         <= 1'b0;
         r_mem_write_data <= '0;
         r_mem_size       <= '0;
      end else begin
         r_i_ack      <= 1'b0;
         r_d_ack      <= 1'b0;
         r_err        <= 1'b0;
         r_mem_rw_req <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_any_req) begin
                  r_owner_d    <= w_grant_d;
                  r_mem_rw_req <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= StIssue;
                  if (w_grant_d) begin
                     r_mem_address    <= d_address;
                     r_mem_rw         <= d_rw;
                     r_mem_write_data <= d_write_data;
                     r_mem_size       <= d_size;
                  end else begin
                     r_mem_address    <= i_address;
                     r_mem_rw         <= 1'b0;
                     r_mem_write_data <= '0;
                     r_mem_size       <= 2'd2;
                  end
               end
            end
            StIssue: begin
               r_cnt   <= '0;
               r_state <= StWait;
            end
            StWait: begin
               // Data beats the watchdog when both land on the same edge
               if (mem_data_valid) begin
                  r_rdata <= mem_read_data;
                  r_i_ack <= ~r_owner_d;
                  r_d_ack <= r_owner_d;
                  r_state <= StResp;
               end else if (w_timeout) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_i_ack <= ~r_owner_d;
                  r_d_ack <= r_owner_d;
                  r_state <= StResp;
               end else begin
                  r_cnt <= w_cnt_inc[15:0];
               end
            end
            StResp: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign i_ack          = r_i_ack;
   assign d_ack          = r_d_ack;
   assign err            = r_err;
   assign busy           = r_busy;
   assign rdata          = r_rdata;
   assign mem_rw_req     = r_mem_rw_req;
   assign mem_address    = r_mem_address;
   assign mem_rw         = r_mem_rw;
   assign mem_write_data = r_mem_write_data;
   assign mem_size       = r_mem_size;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus hand sequences
// for reset, stray data_valid, reset during WAIT and tie arbitration (MEM_ARB_RR_EN aware).
module tb_mem_arbiter;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_address = '0;
   logic        i_ack;
   logic        d_req = 1'b0;
   logic        d_rw = 1'b0;
   logic [31:0] d_address = '0;
   logic [31:0] d_write_data = '0;
   logic [1:0]  d_size = '0;
   logic        d_ack;
   logic [31:0] rdata;
   logic        err;
   logic        busy;
   logic        mem_rw_req;
   logic [31:0] mem_address;
   logic        mem_rw;
   logic [31:0] mem_write_data;
   logic [1:0]  mem_size;
   logic [31:0] mem_read_data = '0;
   logic        mem_data_valid = 1'b0;

   logic [127:0] w_outs;
   assign w_outs = {24'd0, mem_rw_req, mem_address, mem_rw, mem_write_data, mem_size, rdata,
                    i_ack, d_ack, err, busy};

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req          (i_req),
      .i_address      (i_address),
      .i_ack          (i_ack),
      .d_req          (d_req),
      .d_rw           (d_rw),
      .d_address      (d_address),
      .d_write_data   (d_write_data),
      .d_size         (d_size),
      .d_ack          (d_ack),
      .rdata          (rdata),
      .err            (err),
      .busy           (busy),
      .mem_rw_req     (mem_rw_req),
      .mem_address    (mem_address),
      .mem_rw         (mem_rw),
      .mem_write_data (mem_write_data),
      .mem_size       (mem_size),
      .mem_read_data  (mem_read_data),
      .mem_data_valid (mem_data_valid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // delay = cycles from the ISSUE cycle to the mem_data_valid pulse; 0 = controller never answers
   typedef struct {
      logic        is_d;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      int          delay;
      logic [31:0] ret;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_rw;
      logic [1:0]  exp_size;
   } vec_t;

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_vec(input vec_t v, input string tag);
      int          cyc = 0;
      int          issue_t = -1;
      int          pulses = 0;
      int          cd = 0;
      int          exp_lat;
      logic        got_ack = 1'b0;
      logic        stable_ok = 1'b1;
      logic [66:0] snap = '0;
      if (v.is_d) begin
         i_req = 1'b0;
         d_req = 1'b1;
         d_address = v.addr;
      end else begin
         d_req = 1'b0;
         i_req = 1'b1;
         i_address = v.addr;
         d_address = ~v.addr;
      end
      d_rw = v.rw;
      d_write_data = v.wdata;
      d_size = v.size;
      exp_lat = (v.delay == 0) ? int'(TO) + 1 : v.delay + 1;
      while (!got_ack && cyc < 40) begin
         @(negedge clk);
         cyc++;
         mem_data_valid = 1'b0;
         if (i_ack || d_ack) begin
            got_ack = 1'b1;
            check({tag, "_ack_who"}, {126'd0, i_ack, d_ack}, v.is_d ? 128'd1 : 128'd2);
            check({tag, "_rdata"}, {96'd0, rdata}, {96'd0, v.exp_rdata});
            check({tag, "_err"}, {127'd0, err}, {127'd0, v.exp_err});
            check({tag, "_latency"}, 128'(cyc - issue_t), 128'(exp_lat));
            i_req = 1'b0;
            d_req = 1'b0;
         end else if (mem_rw_req) begin
            pulses++;
            if (issue_t < 0) begin
               issue_t = cyc;
               check({tag, "_mem_addr"}, {96'd0, mem_address}, {96'd0, v.addr});
               check({tag, "_mem_rw"}, {127'd0, mem_rw}, {127'd0, v.exp_rw});
               check({tag, "_mem_size"}, {126'd0, mem_size}, {126'd0, v.exp_size});
               if (v.is_d) check({tag, "_mem_wdata"}, {96'd0, mem_write_data}, {96'd0, v.wdata});
               snap = {mem_address, mem_rw, mem_write_data, mem_size};
            end
            cd = v.delay;
         end else if (issue_t >= 0) begin
            if (snap != {mem_address, mem_rw, mem_write_data, mem_size}) stable_ok = 1'b0;
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  mem_data_valid = 1'b1;
                  mem_read_data = v.ret;
               end
            end
         end
      end
      mem_data_valid = 1'b0;
      i_req = 1'b0;
      d_req = 1'b0;
      check({tag, "_ack_seen"}, {127'd0, got_ack}, 128'd1);
      check({tag, "_one_issue"}, 128'(pulses), 128'd1);
      check({tag, "_wait_stable"}, {127'd0, stable_ok}, 128'd1);
      @(negedge clk);
      check({tag, "_back_idle"}, {125'd0, i_ack, d_ack, busy}, 128'd0);
   endtask

   vec_t vecs[7];

   initial begin
      logic [31:0] prev_rdata;
      logic        found;
      logic        order[4];
      logic        exp_order[4];
      int          nack;
      int          cd;
      vec_t        rv;

      vecs[0] = '{1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 2'd0, 6, 32'h13, 32'h13, 1'b0, 1'b0, 2'd2};
      vecs[1] = '{1'b1, 1'b1, 32'h101, 32'hA5, 2'd0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1,
                  2'd0};
      vecs[2] = '{1'b1, 1'b0, 32'h202, 32'h0, 2'd1, 1, 32'h1234, 32'h1234, 1'b0, 1'b0, 2'd1};
      vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FF00, 32'h55, 2'd2, 2, 32'h0, 32'h0, 1'b0, 1'b1, 2'd2};
      vecs[4] = '{1'b0, 1'b0, 32'h40, 32'h0, 2'd2, 0, 32'h9999, 32'h0, 1'b1, 1'b0, 2'd2};
      vecs[5] = '{1'b1, 1'b0, 32'h500, 32'h0, 2'd2, 8, 32'hCAFE, 32'hCAFE, 1'b0, 1'b0, 2'd2};
      vecs[6] = '{1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 0, 32'h1111, 32'h0, 1'b1, 1'b0, 2'd2};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_state", w_outs, 128'd0);
      reset = 1'b1;
      @(negedge clk);

      // Stray data_valid while idle
      prev_rdata = rdata;
      mem_data_valid = 1'b1;
      mem_read_data = 32'hBAD0BAD0;
      @(negedge clk);
      mem_data_valid = 1'b0;
      check("stray_no_ack", {125'd0, i_ack, d_ack, busy}, 128'd0);
      @(negedge clk);
      check("stray_quiet", {124'd0, i_ack, d_ack, err, busy}, 128'd0);
      check("stray_rdata", {96'd0, rdata}, {96'd0, prev_rdata});

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset during WAIT, then the still-pending d_req is reissued
      d_req = 1'b1;
      d_rw = 1'b0;
      d_address = 32'h300;
      d_size = 2'd2;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (mem_rw_req) found = 1'b1;
      end
      check("rst_first_issue", {127'd0, found}, 128'd1);
      repeat (3) @(negedge clk);
      check("rst_busy_in_wait", {127'd0, busy}, 128'd1);
      reset = 1'b0;
      #1;
      check("rst_async_clear", w_outs, 128'd0);
      @(negedge clk);
      check("rst_no_ack", w_outs, 128'd0);
      reset = 1'b1;
      rv = '{1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 1, 32'h77, 32'h77, 1'b0, 1'b0, 2'd2};
      run_vec(rv, "reissue");

      // Both clients requesting continuously, from a fresh reset
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      i_req = 1'b1;
      i_address = 32'h1000;
      d_req = 1'b1;
      d_rw = 1'b0;
      d_address = 32'h2000;
      d_size = 2'd2;
      nack = 0;
      cd = 0;
      for (int k = 0; k < 100 && nack < 4; k++) begin
         @(negedge clk);
         mem_data_valid = 1'b0;
         if (i_ack || d_ack) begin
            order[nack] = d_ack;
            nack++;
         end
         if (mem_rw_req) begin
            cd = 2;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               mem_data_valid = 1'b1;
               mem_read_data = 32'h4242;
            end
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      mem_data_valid = 1'b0;
      check("arb_ack_count", 128'(nack), 128'd4);
`ifdef MEM_ARB_RR_EN
      exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      for (int k = 0; k < 4; k++) begin
         if (k < nack) check($sformatf("arb_order%0d", k), {127'd0, order[k]},
                             {127'd0, exp_order[k]});
      end
      repeat (3) @(negedge clk);
      check("arb_idle", {127'd0, busy}, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter between the CPU's instruction-fetch port and its load/store port, upstream of `memory_cont`. It takes one request at a time, drives the controller's single request interface (`rw_req` pulse, held address/rw/data/size), waits for `data_valid`, and returns a registered response with a one-cycle acknowledge to the owning client. A watchdog aborts transactions the controller never completes, so the CPU cannot hang.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles before abort, range 1..65535; 0 disables the watchdog.
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `i_req`  in  1  instruction fetch request, level; held until `i_ack`.
- `i_address`  in  32  fetch address (always word read).
- `i_ack`  out  1  one-cycle pulse: fetch complete, `rdata` valid.
- `d_req`  in  1  data request, level; held until `d_ack`.
- `d_rw`  in  1  0 = read, 1 = write.
- `d_address`  in  32  data address.
- `d_write_data`  in  32  store data.
- `d_size`  in  2  0 = byte, 1 = half, 2 = word.
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `rdata`  out  32  registered read data for the acked client.
- `err`  out  1  pulses with the ack when the transaction was aborted by the watchdog.
- `busy`  out  1  high in every state except IDLE.
- `mem_rw_req`  out  1  to controller `rw_req`.
- `mem_address`  out  32  to controller `address`.
- `mem_rw`  out  1  to controller `rw`.
- `mem_write_data`  out  32  to controller `write_data`.
- `mem_size`  out  2  to controller `size`.
- `mem_read_data`  in  32  from controller `read_data`.
- `mem_data_valid`  in  1  from controller `data_valid`, one-cycle pulse.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If any request is pending, pick the owner and latch its address, rw, write data and size into the `mem_*` registers.
  - An instruction owner forces rw = 0 and size = 2.
  - Go to ISSUE.
- ISSUE: `mem_rw_req` = 1 for exactly this cycle; go to WAIT. The watchdog counter is cleared.
- WAIT:
  - `mem_rw_req` = 0. All other `mem_*` outputs stay frozen, because the controller re-samples `rw` and `write_data` mid-transaction.
  - On `mem_data_valid` = 1: capture `mem_read_data` into `rdata` and go to RESP.
  - Otherwise the counter increments. When it reaches `TIMEOUT` (TIMEOUT ≠ 0), set the abort flag, load 0 into `rdata` and go to RESP.
- RESP:
  - The owner's ack = 1 for one cycle; `err` = abort flag.
  - Go to IDLE.
  - The controller is in its idle state during this cycle, so back-to-back issue is legal.
- Writes ack exactly like reads; `rdata` then holds whatever the controller presents.
- A write to address 0xFFFFFF00 (port register) follows the same sequence; no special case.
- A client dropping `req` before its ack: the transaction still completes and the ack still pulses. Clients must not do this.
- A new request arriving during ISSUE/WAIT/RESP waits in IDLE arbitration.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - All `mem_*` outputs, `rdata`, `i_ack`, `d_ack`, `err` and `busy` = 0.
  - Round-robin pointer = instruction.
- Reset mid-transaction aborts with no ack. The controller is reset by the same signal.
- Best-case latency from `req` seen in IDLE (edge N) to the ack-high cycle: ISSUE is N+1, controller delay, WAIT ends on the `mem_data_valid` edge, and the ack is high the cycle after.
- Minimum request-to-request spacing is 4 cycles plus the controller delay.
- `mem_data_valid` is only honoured in WAIT. A pulse in any other state is ignored.
- If `mem_data_valid` and the timeout occur on the same edge, the data wins and `err` = 0.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - When both requests are pending in IDLE, grant the client not served last.
  - The pointer updates on every grant.
  - After reset the pointer is instruction, so data wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins ties. The pointer register is not built.

## Test plan
- Single fetch: `i_req` = 1, `i_address` = 0x20, controller model returns 0x00000013 after 6 cycles → one `mem_rw_req` pulse, `i_ack` one cycle, `rdata` = 0x00000013, `err` = 0.
- Byte store: `d_rw` = 1, `d_size` = 0, `d_address` = 0x101, `d_write_data` = 0xA5 → `mem_size` = 0, `mem_rw` = 1 and `mem_write_data` = 0xA5 stable from ISSUE through WAIT; `d_ack` pulses once.
- Both requesting continuously for 4 transactions → `MEM_ARB_RR_EN`: order data, instr, data, instr. Without it: data ×4 while `d_req` stays high.
- Controller never asserts `mem_data_valid`, `TIMEOUT` = 8 → ack + `err` = 1 exactly 8 WAIT cycles after ISSUE, `rdata` = 0, returns to IDLE.
- `reset` pulled low during WAIT → all outputs 0 immediately, no ack. After release, a pending `d_req` is reissued.
- Stray `mem_data_valid` pulse while IDLE → no ack, no state change.
